spi_frame_rx: RTL and testbench



---
 rtl/spi_frame_rx.sv | 165 ++++++++++++++++
 tb/tb_spi_frame_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronises raw SCLK/COPI/nCS pins, deserialises
// 16-bit MSB-first frames and emits a one-cycle write strobe or a length error.
module spi_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  output logic              busy
);

  localparam int FRAME_BITS = 1 + ADDR_W + DATA_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic                   r_d_sclk;
  logic                   r_d_ncs;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [FRAME_BITS-1:0]  r_shift;
  logic [FRAME_BITS-1:0]  w_shift_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_wr_valid;
  logic                   w_wr_valid_nxt;
  logic                   r_frame_err;
  logic                   w_frame_err_nxt;
  logic [ADDR_W-1:0]      r_wr_addr;
  logic [ADDR_W-1:0]      w_wr_addr_nxt;
  logic [DATA_W-1:0]      r_wr_data;
  logic [DATA_W-1:0]      w_wr_data_nxt;
  logic                   r_busy;

  logic w_s_sclk;
  logic w_s_copi;
  logic w_s_ncs;
  logic w_ncs_fall;
  logic w_ncs_rise;
  logic w_sclk_rise;

  assign w_s_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_s_copi = r_copi_sync[SYNC_STAGES-1];
  assign w_s_ncs  = r_ncs_sync[SYNC_STAGES-1];

  // SCLK edges are gated by nCS so a simultaneous deselect wins over a clock edge.
  assign w_ncs_fall  = !w_s_ncs && r_d_ncs;
  assign w_ncs_rise  = w_s_ncs && !r_d_ncs;
  assign w_sclk_rise = w_s_sclk && !r_d_sclk && !w_s_ncs;

  // Pin synchronisers plus edge-detect history, reset to the idle bus state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= {SYNC_STAGES{1'b0}};
      r_copi_sync <= {SYNC_STAGES{1'b0}};
      r_ncs_sync  <= {SYNC_STAGES{1'b1}};
      r_d_sclk    <= 1'b0;
      r_d_ncs     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_d_sclk    <= w_s_sclk;
      r_d_ncs     <= w_s_ncs;
    end
  end

  // State, shift register, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= {FRAME_BITS{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_wr_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= {ADDR_W{1'b0}};
      r_wr_data   <= {DATA_W{1'b0}};
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wr_valid  <= w_wr_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_busy      <= !w_s_ncs;
    end
  end

  // Next-state and frame evaluation; a frame is judged in the cycle nCS rises.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_wr_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    case (r_state)
      ST_IDLE: begin
        if (w_ncs_fall) begin
          w_state_nxt = ST_SHIFT;
          w_shift_nxt = {FRAME_BITS{1'b0}};
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_ncs_rise) begin
          w_state_nxt = ST_IDLE;
          if (r_cnt == CNT_FRAME) begin
            if (r_shift[FRAME_BITS-1]) begin
              w_wr_valid_nxt = 1'b1;
              w_wr_addr_nxt  = r_shift[FRAME_BITS-2 -: ADDR_W];
              w_wr_data_nxt  = r_shift[DATA_W-1:0];
            end else begin
              w_wr_valid_nxt = 1'b0;
            end
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end else if (w_sclk_rise) begin
          w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_s_copi};
          if (r_cnt != CNT_SAT) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign wr_valid  = r_wr_valid;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: a monitor captures write strobes into a
// queue which each scenario task compares against its expected-write queue.
module tb_spi_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_err   = 0;
  bit overlap = 1'b0;
  logic [14:0] exp_q[$];
  logic [14:0] obs_q[$];

  spi_frame_rx #(.SYNC_STAGES(2), .ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Output monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wr_valid === 1'b1) begin
        n_valid++;
        obs_q.push_back({wr_addr, wr_data});
      end
      if (frame_err === 1'b1) n_err++;
      if (wr_valid === 1'b1 && frame_err === 1'b1) overlap = 1'b1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    ncs = 1'b0;
    wait_clk(4);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(4);
  endtask

  task automatic end_frame();
    ncs = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    n_tests++;
    if ({wr_valid, frame_err, busy, wr_addr, wr_data} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b e=%b b=%b a=%h d=%h, expected all 0",
               wr_valid, frame_err, busy, wr_addr, wr_data);
    end
  endtask

  task automatic test_write();
    int v0 = n_valid;
    exp_q.push_back({7'h04, 8'hAA});
    send_bits(32'h84AA, 16);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL write_busy: got %b, expected 1", busy);
    end
    ncs = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++;
    if (wr_valid !== 1'b0) begin
      n_fail++; $display("FAIL write_early: wr_valid=%b one edge after sample, expected 0", wr_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if (wr_valid !== 1'b1) begin
      n_fail++; $display("FAIL write_latency: wr_valid=%b two edges after sample, expected 1", wr_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if (wr_valid !== 1'b0) begin
      n_fail++; $display("FAIL write_pulse: wr_valid=%b after one cycle, expected 0", wr_valid);
    end
    wait_clk(6);
    n_tests++;
    if (n_valid - v0 != 1 || obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL write_count: got %0d pulses, expected 1", n_valid - v0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [14:0] e = exp_q.pop_front();
      logic [14:0] o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL write_data: got a=%h d=%h, expected a=%h d=%h", o[14:8], o[7:0], e[14:8], e[7:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_read();
    int v0 = n_valid;
    int e0 = n_err;
    send_bits(32'h04AA, 16);
    end_frame();
    n_tests++;
    if (n_valid != v0 || n_err != e0 || wr_addr !== 7'h04 || wr_data !== 8'hAA) begin
      n_fail++;
      $display("FAIL read_drop: got %0d writes %0d errs a=%h d=%h, expected 0 0 a=04 d=AA",
               n_valid - v0, n_err - e0, wr_addr, wr_data);
    end
    obs_q.delete();
  endtask

  task automatic test_len_err();
    int v0 = n_valid;
    int e0 = n_err;
    send_bits(32'h4255, 15);
    end_frame();
    n_tests++;
    if (n_err - e0 != 1 || n_valid != v0 || wr_addr !== 7'h04 || wr_data !== 8'hAA) begin
      n_fail++;
      $display("FAIL short_frame: got %0d errs %0d writes a=%h d=%h, expected 1 0 a=04 d=AA",
               n_err - e0, n_valid - v0, wr_addr, wr_data);
    end
    v0 = n_valid; e0 = n_err;
    send_bits(32'h1_0955, 17);
    end_frame();
    n_tests++;
    if (n_err - e0 != 1 || n_valid != v0 || wr_addr !== 7'h04 || wr_data !== 8'hAA) begin
      n_fail++;
      $display("FAIL long_frame: got %0d errs %0d writes a=%h d=%h, expected 1 0 a=04 d=AA",
               n_err - e0, n_valid - v0, wr_addr, wr_data);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int v0;
    int e0 = n_err;
    send_bits(32'h81, 8);
    rst_n = 1'b0; ncs = 1'b1; sclk = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(6);
    n_tests++;
    if (n_err != e0 || {wr_valid, frame_err, busy, wr_addr, wr_data} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got %0d errs a=%h d=%h b=%b, expected 0 errs all 0",
               n_err - e0, wr_addr, wr_data, busy);
    end
    v0 = n_valid; e0 = n_err;
    exp_q.push_back({7'h01, 8'h55});
    send_bits(32'h8155, 16);
    end_frame();
    n_tests++;
    if (n_valid - v0 != 1 || n_err != e0 || obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL reset_recover_count: got %0d writes %0d errs, expected 1 0", n_valid - v0, n_err - e0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [14:0] e = exp_q.pop_front();
      logic [14:0] o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL reset_recover_data: got a=%h d=%h, expected a=%h d=%h", o[14:8], o[7:0], e[14:8], e[7:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    exp_q.push_back({7'h02, 8'h11});
    exp_q.push_back({7'h03, 8'hFF});
    send_bits(32'h8211, 16);
    ncs = 1'b1;
    wait_clk(3);
    send_bits(32'h83FF, 16);
    end_frame();
    n_tests++;
    if (n_valid - v0 != 2 || obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d writes, expected 2", n_valid - v0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [14:0] e = exp_q.pop_front();
      logic [14:0] o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL b2b_data: got a=%h d=%h, expected a=%h d=%h", o[14:8], o[7:0], e[14:8], e[7:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_idle_sclk();
    int v0 = n_valid;
    int e0 = n_err;
    bit busy_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      copi = i[0];
      sclk = 1'b1; wait_clk(4);
      if (busy !== 1'b0) busy_seen = 1'b1;
      sclk = 1'b0; wait_clk(4);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    n_tests++;
    if (busy_seen || n_valid != v0 || n_err != e0) begin
      n_fail++; $display("FAIL idle_sclk: got busy_seen=%b %0d writes %0d errs, expected 0 0 0",
                         busy_seen, n_valid - v0, n_err - e0);
    end
    exp_q.push_back({7'h07, 8'h01});
    send_bits(32'h8701, 16);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL idle_busy_frame: got %b, expected 1", busy);
    end
    end_frame();
    n_tests++;
    if (busy !== 1'b0 || n_valid - v0 != 1 || obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL idle_after: got busy=%b %0d writes, expected 0 1", busy, n_valid - v0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [14:0] e = exp_q.pop_front();
      logic [14:0] o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL idle_data: got a=%h d=%h, expected a=%h d=%h", o[14:8], o[7:0], e[14:8], e[7:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_no_overlap();
    n_tests++;
    if (overlap) begin
      n_fail++; $display("FAIL overlap: wr_valid and frame_err high together, got 1 expected 0");
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_len_err();
    test_reset_mid();
    test_back_to_back();
    test_idle_sclk();
    test_no_overlap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
